fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of decode/control. It owns the PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to decode. A jump from the control path (PC_JUMP with its target) redirects fetch, flushes buffered words and squashes responses still in flight.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic              imem_req_valid_o;
    logic              imem_req_ready_i;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_rsp_valid_i;
    logic [DWIDTH-1:0] imem_rsp_data_i;

    modport master (
        output imem_req_valid_o, imem_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers returned
// words with their PCs and hands one per cycle to decode; jumps flush and squash.
module fetch_stage #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_stage_if.master     imem,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    input  logic              stall_i,
    output logic              insn_valid_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int OCCW = CW + 1;
    localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h00000013);

    logic [AWIDTH-1:0]              pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]                  inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0][DWIDTH-1:0]   insn_mem_q, insn_mem_d;
    logic [DEPTH-1:0][AWIDTH-1:0]   pc_mem_q, pc_mem_d;

    logic [OCCW-1:0]   occ;
    logic              req_valid, req_fire, rsp_ok, push, pop;
    logic [AWIDTH-1:0] target;

    // Words still in flight count against buffer space so a response always has a slot.
    assign occ       = OCCW'(inflight_q) + OCCW'(count_q);
    assign req_valid = rst_n && !redirect_i && (occ < OCCW'(DEPTH));
    assign req_fire  = req_valid && imem.imem_req_ready_i;
    assign rsp_ok    = imem.imem_rsp_valid_i && (inflight_q != '0);
    assign push      = rsp_ok && (drop_q == '0);
    assign pop       = insn_valid_o && !stall_i;
    assign target    = redirect_pc_i & ~AWIDTH'(3);

    assign imem.imem_req_valid_o = req_valid;
    assign imem.imem_addr_o      = pc_q;

    assign insn_valid_o = (count_q != '0);
    assign insn_o       = insn_valid_o ? insn_mem_q[rd_ptr_q] : NOP;
    assign pc_o         = insn_valid_o ? pc_mem_q[rd_ptr_q]   : BASEADDR;

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        insn_mem_d = insn_mem_q;
        pc_mem_d   = pc_mem_q;
        if (redirect_i) begin
            // Everything still outstanding becomes garbage, including a word landing now.
            pc_d       = target;
            rsp_pc_d   = target;
            inflight_d = inflight_q - CW'(rsp_ok);
            drop_d     = inflight_q - CW'(rsp_ok);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire)
                pc_d = pc_q + AWIDTH'(4);
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
            if (rsp_ok && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (push) begin
                insn_mem_d[wr_ptr_q] = imem.imem_rsp_data_i;
                pc_mem_d[wr_ptr_q]   = rsp_pc_q;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                rsp_pc_d             = rsp_pc_q + AWIDTH'(4);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= BASEADDR;
            rsp_pc_q   <= BASEADDR;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            insn_mem_q <= '0;
            pc_mem_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            insn_mem_q <= insn_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model returns addr^0xFFFF in order,
// a monitor checks every word decode consumes against the expected PC stream.
module tb_fetch_stage;
    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        insn_valid_o;
    logic [31:0] insn_o, pc_o;

    fetch_stage_if #(.AWIDTH(32), .DWIDTH(32)) imem_if ();

    fetch_stage #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_if),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i      (stall_i),
        .insn_valid_o (insn_valid_o),
        .insn_o       (insn_o),
        .pc_o         (pc_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mq[$];
    bit hold = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic load_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_first(input string nm, input logic [31:0] epc);
        int i;
        i = 0;
        while (!insn_valid_o && i < 20) begin
            @(negedge clk); #1;
            i++;
        end
        if (!insn_valid_o) begin
            total++; bad++;
            $display("FAIL %s: no insn within 20 cycles, want pc %h", nm, epc);
        end else check(nm, pc_o, epc);
    endtask

    // In-order memory: accepted addresses queue up, one returned per cycle unless held.
    initial begin
        imem_if.imem_req_ready_i = 1'b1;
        imem_if.imem_rsp_valid_i = 1'b0;
        imem_if.imem_rsp_data_i  = '0;
        forever begin
            @(negedge clk); #2;
            if (rst_n && imem_if.imem_req_valid_o && imem_if.imem_req_ready_i)
                mq.push_back(imem_if.imem_addr_o);
            @(posedge clk); #1;
            if (!rst_n) begin
                mq.delete();
                imem_if.imem_rsp_valid_i = 1'b0;
            end else if (!hold && mq.size() > 0) begin
                imem_if.imem_rsp_valid_i = 1'b1;
                imem_if.imem_rsp_data_i  = mq.pop_front() ^ 32'h0000FFFF;
            end else imem_if.imem_rsp_valid_i = 1'b0;
        end
    end

    // Monitor: every word decode takes must be the next expected one.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk); #3;
            if (rst_n && !redirect_i && insn_valid_o && !stall_i) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_extra: got pc %h want none", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc_o, e);
                    check("sb_insn", insn_o, e ^ 32'h0000FFFF);
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0;
        load_exp(BASE);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_if.imem_req_valid_o), 0);
        check("rst_addr", imem_if.imem_addr_o, BASE);
        check("rst_insn_valid", 32'(insn_valid_o), 0);
        check("rst_insn", insn_o, NOP);
        check("rst_pc", pc_o, BASE);

        // Release with decode stalled: latency, then fill to two entries.
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; stall_i = 1'b1;
        @(negedge clk); #1;
        check("lat_cycle1_valid", 32'(insn_valid_o), 0);
        @(negedge clk); #1;
        check("lat_cycle2_valid", 32'(insn_valid_o), 1);
        check("lat_cycle2_pc", pc_o, BASE);
        repeat (4) @(negedge clk);
        #1;
        check("fill_req_valid", 32'(imem_if.imem_req_valid_o), 0);
        check("fill_insn_valid", 32'(insn_valid_o), 1);
        check("fill_pc", pc_o, BASE);
        check("fill_insn", insn_o, BASE ^ 32'h0000FFFF);
        check("fill_addr", imem_if.imem_addr_o, BASE + 32'd8);
        @(negedge clk);
        stall_i = 1'b0;
        repeat (10) @(negedge clk);

        // Request backpressure: address must hold while not accepted.
        imem_if.imem_req_ready_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        a0 = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(imem_if.imem_req_valid_o), 1);
            check("bp_addr", imem_if.imem_addr_o, a0);
            @(negedge clk); #1;
        end
        imem_if.imem_req_ready_i = 1'b1;
        @(negedge clk); #1;
        check("bp_resume_addr", imem_if.imem_addr_o, a0 + 32'd4);
        repeat (6) @(negedge clk);

        // Redirect with two requests in flight: both late words are dropped.
        hold = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rd2_req_valid", 32'(imem_if.imem_req_valid_o), 0);
        check("rd2_insn_valid", 32'(insn_valid_o), 0);
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h01000103;
        load_exp(32'h01000100);
        #1;
        check("rd2_no_req", 32'(imem_if.imem_req_valid_o), 0);
        @(negedge clk);
        redirect_i = 1'b0; hold = 1'b0;
        #1;
        check("rd2_align_addr", imem_if.imem_addr_o, 32'h01000100);
        wait_first("rd2_first_pc", 32'h01000100);
        repeat (8) @(negedge clk);

        // Redirect on the same edge as a response and a pop.
        hold = 1'b1;
        repeat (5) @(negedge clk);
        stall_i = 1'b1; hold = 1'b0;
        @(negedge clk); @(negedge clk);
        a0 = exp_q[0];
        stall_i = 1'b0; hold = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'h01000101;
        #1;
        check("co_pre_valid", 32'(insn_valid_o), 1);
        check("co_pre_pc", pc_o, a0);
        check("co_pre_rsp", 32'(imem_if.imem_rsp_valid_i), 1);
        load_exp(32'h01000100);
        @(negedge clk);
        redirect_i = 1'b0; hold = 1'b0;
        #1;
        check("co_flush_valid", 32'(insn_valid_o), 0);
        check("co_req_valid", 32'(imem_if.imem_req_valid_o), 1);
        check("co_req_addr", imem_if.imem_addr_o, 32'h01000100);
        wait_first("co_first_pc", 32'h01000100);
        repeat (8) @(negedge clk);

        // Asynchronous reset between edges.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("ar_insn_valid", 32'(insn_valid_o), 0);
        check("ar_req_valid", 32'(imem_if.imem_req_valid_o), 0);
        check("ar_addr", imem_if.imem_addr_o, BASE);
        check("ar_pc", pc_o, BASE);
        check("ar_insn", insn_o, NOP);
        load_exp(BASE);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ar_restart_addr", imem_if.imem_addr_o, BASE);
        wait_first("ar_first_pc", BASE);
        repeat (10) @(negedge clk);

        total++;
        if (n_pop < 20) begin
            bad++;
            $display("FAIL sb_volume: got %0d consumed want >=20", n_pop);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
